// File: rtl/seg_entry_ctrl.sv
// rtl/seg_entry_ctrl.sv - keypad digit entry buffer with display sweep and commit
// Optional: define SEG_ENTRY_COMMIT_CLR_EN to clear the entry after a committing enter.
module seg_entry_ctrl #(
    parameter int SEG_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             key_val,
    input  logic                   key_vld,
    output logic [4*SEG_NUM-1:0]   din,
    output logic [SEG_NUM-1:0]     din_vld,
    output logic [4*SEG_NUM-1:0]   num_out,
    output logic                   num_vld,
    output logic                   full,
    output logic                   key_drop
);

    localparam int W  = 4 * SEG_NUM;
    localparam int CW = $clog2(SEG_NUM + 1);
    localparam int IW = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic            r_armed;
    logic [W-1:0]    r_buf, w_buf_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_hold_vld, w_hold_vld_nxt;
    logic [3:0]      r_hold_key, w_hold_key_nxt;
    logic [W-1:0]    r_num_out, w_num_out_nxt;
    logic            r_num_vld, w_num_vld_nxt;
    logic            r_key_drop, w_drop_nxt;
    logic            r_full;

    logic            w_key_go;
    logic [3:0]      w_key;
    logic            w_sweep;
    logic [W+3:0]    w_up_ext;
    logic [W+3:0]    w_dn_ext;

    assign w_dn_ext = {4'hF, r_buf};

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_buf_nxt      = r_buf;
        w_cnt_nxt      = r_cnt;
        w_hold_vld_nxt = r_hold_vld;
        w_hold_key_nxt = r_hold_key;
        w_num_out_nxt  = r_num_out;
        w_num_vld_nxt  = 1'b0;
        w_drop_nxt     = 1'b0;
        w_key_go       = 1'b0;
        w_key          = key_val;
        w_sweep        = 1'b0;

        if (r_state != IDLE) begin
            if (key_vld) begin
                if (r_hold_vld) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_hold_vld_nxt = 1'b1;
                    w_hold_key_nxt = key_val;
                end
            end
            // The first edge after reset release only arms the sweep, so din_vld stays low in reset.
            if (r_armed) begin
                if (r_idx == IW'(SEG_NUM - 1)) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + IW'(1);
                end
            end
        end else begin
            if (r_hold_vld) begin
                w_key_go       = 1'b1;
                w_key          = r_hold_key;
                w_hold_vld_nxt = key_vld;
                w_hold_key_nxt = key_val;
            end else if (key_vld) begin
                w_key_go = 1'b1;
                w_key    = key_val;
            end
        end

        w_up_ext = {r_buf, w_key};

        if (w_key_go) begin
            case (w_key)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                    if (r_cnt != CW'(SEG_NUM)) begin
                        w_buf_nxt = w_up_ext[W-1:0];
                        w_cnt_nxt = r_cnt + CW'(1);
                        w_sweep   = 1'b1;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end
                4'hA: begin
                    if (r_cnt != '0) begin
                        w_buf_nxt = w_dn_ext[W+3:4];
                        w_cnt_nxt = r_cnt - CW'(1);
                        w_sweep   = 1'b1;
                    end
                end
                4'hB: begin
                    w_buf_nxt = {W{1'b1}};
                    w_cnt_nxt = '0;
                    w_sweep   = 1'b1;
                end
                4'hC: begin
                    if (r_cnt != '0) begin
                        w_num_out_nxt = r_buf;
                        w_num_vld_nxt = 1'b1;
`ifdef SEG_ENTRY_COMMIT_CLR_EN
                        w_buf_nxt     = {W{1'b1}};
                        w_cnt_nxt     = '0;
                        w_sweep       = 1'b1;
`else
                        w_sweep       = 1'b0;
`endif
                    end
                end
                default: begin
                    w_sweep = 1'b0;
                end
            endcase
        end

        if (w_sweep) begin
            w_state_nxt = UPDATE;
            w_idx_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_idx      <= '0;
            r_armed    <= 1'b0;
            r_buf      <= {W{1'b1}};
            r_cnt      <= '0;
            r_hold_vld <= 1'b0;
            r_hold_key <= 4'h0;
            r_num_out  <= {W{1'b1}};
            r_num_vld  <= 1'b0;
            r_key_drop <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_armed    <= 1'b1;
            r_buf      <= w_buf_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold_vld <= w_hold_vld_nxt;
            r_hold_key <= w_hold_key_nxt;
            r_num_out  <= w_num_out_nxt;
            r_num_vld  <= w_num_vld_nxt;
            r_key_drop <= w_drop_nxt;
            r_full     <= (w_cnt_nxt == CW'(SEG_NUM));
        end
    end

    always_comb begin
        din_vld = '0;
        for (int i = 0; i < SEG_NUM; i++) begin
            din_vld[i] = r_armed && (r_state != IDLE) && (r_idx == IW'(i));
        end
    end

    assign din      = r_buf;
    assign num_out  = r_num_out;
    assign num_vld  = r_num_vld;
    assign full     = r_full;
    assign key_drop = r_key_drop;

endmodule

// File: tb/tb_seg_entry_ctrl.sv
// tb/tb_seg_entry_ctrl.sv - directed self-checking bench for seg_entry_ctrl with digit-list model
module tb_seg_entry_ctrl;

    localparam int N = 4;
    localparam int M_WAIT = 0, M_SWEEP = 1, M_IDLE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    key_val = 4'h0;
    logic          key_vld = 1'b0;
    logic [15:0]   din;
    logic [3:0]    din_vld;
    logic [15:0]   num_out;
    logic          num_vld;
    logic          full;
    logic          key_drop;

    int n_chk = 0;
    int n_err = 0;

    int          digs [N];
    int          cnt, mode, pos, hold_v, hold_k;
    logic [15:0] m_num;
    bit          m_nv, m_drop;

    seg_entry_ctrl #(.SEG_NUM(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_val  (key_val),
        .key_vld  (key_vld),
        .din      (din),
        .din_vld  (din_vld),
        .num_out  (num_out),
        .num_vld  (num_vld),
        .full     (full),
        .key_drop (key_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack();
        logic [15:0] p;
        for (int i = 0; i < N; i++) p[4*i +: 4] = 4'(digs[i]);
        return p;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) digs[i] = 15;
        cnt = 0; mode = M_WAIT; pos = 0; hold_v = 0; hold_k = 0;
        m_num = 16'hFFFF; m_nv = 0; m_drop = 0;
    endtask

    task automatic m_apply(input int k, output bit sw);
        sw = 0;
        if (k <= 9) begin
            if (cnt < N) begin
                for (int i = N - 1; i > 0; i--) digs[i] = digs[i-1];
                digs[0] = k; cnt++; sw = 1;
            end else m_drop = 1;
        end else if (k == 10) begin
            if (cnt > 0) begin
                for (int i = 0; i < N - 1; i++) digs[i] = digs[i+1];
                digs[N-1] = 15; cnt--; sw = 1;
            end
        end else if (k == 11) begin
            for (int i = 0; i < N; i++) digs[i] = 15;
            cnt = 0; sw = 1;
        end else if (k == 12) begin
            if (cnt > 0) begin
                m_num = pack(); m_nv = 1;
`ifdef SEG_ENTRY_COMMIT_CLR_EN
                for (int i = 0; i < N; i++) digs[i] = 15;
                cnt = 0; sw = 1;
`endif
            end
        end
    endtask

    // Behavioural model: a digit list, a one-slot hold and a sweep position.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            bit have, sw;
            int k;
            m_nv = 0; m_drop = 0; have = 0; k = 0;
            if (mode != M_IDLE) begin
                if (key_vld) begin
                    if (hold_v != 0) m_drop = 1;
                    else begin hold_v = 1; hold_k = int'(key_val); end
                end
                if (mode == M_WAIT) begin mode = M_SWEEP; pos = 0; end
                else if (pos == N - 1) mode = M_IDLE;
                else pos++;
            end else begin
                if (hold_v != 0) begin
                    k = hold_k; have = 1; hold_v = 0;
                    if (key_vld) begin hold_v = 1; hold_k = int'(key_val); end
                end else if (key_vld) begin
                    k = int'(key_val); have = 1;
                end
                if (have) begin
                    m_apply(k, sw);
                    if (sw) begin mode = M_SWEEP; pos = 0; end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] ev;
        ev = (mode == M_SWEEP) ? 4'(1 << pos) : 4'b0000;
        chk("din_vld", 32'(din_vld), 32'(ev));
        chk("din", 32'(din), 32'(pack()));
        chk("full", 32'(full), 32'(cnt == N));
        chk("num_vld", 32'(num_vld), 32'(m_nv));
        chk("num_out", 32'(num_out), 32'(m_num));
        chk("key_drop", 32'(key_drop), 32'(m_drop));
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [3:0] v);
        key_val = v; key_vld = 1'b1;
        @(posedge clk); #1;
        key_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        m_reset();
        @(posedge clk); #1;
        idle(1);
        chk("rst_din_vld", 32'(din_vld), 32'h0);
        chk("rst_din", 32'(din), 32'hFFFF);
        chk("rst_num_out", 32'(num_out), 32'hFFFF);
        chk("rst_full", 32'(full), 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("init_sweep", 32'(din_vld), 32'(4'b0001 << i));
            chk("init_din", 32'(din), 32'hFFFF);
        end
        idle(1);
        chk("init_done", 32'(din_vld), 32'h0);

        send(4'h1);
        chk("key_to_sweep", 32'(din_vld), 32'h1);
        idle(5); send(4'h2); idle(5); send(4'h3); idle(5);
        chk("din_123", 32'(din), 32'hF123);
        chk("full_3", 32'(full), 32'h0);
        send(4'h4); idle(5);
        chk("din_1234", 32'(din), 32'h1234);
        chk("full_4", 32'(full), 32'h1);
        send(4'h5);
        chk("drop_full", 32'(key_drop), 32'h1);
        chk("drop_nosweep", 32'(din_vld), 32'h0);
        idle(5);

        send(4'hA); idle(5);
        chk("bksp", 32'(din), 32'hF123);
        send(4'hB); idle(5);
        chk("clear", 32'(din), 32'hFFFF);
        send(4'hA);
        chk("bksp_empty", 32'(din_vld), 32'h0);
        idle(5);

        send(4'h5); idle(5); send(4'h6); idle(5);
        send(4'hC);
        chk("enter_vld", 32'(num_vld), 32'h1);
        chk("enter_num", 32'(num_out), 32'hFF56);
        idle(1);
        chk("enter_pulse", 32'(num_vld), 32'h0);
        idle(5);
`ifdef SEG_ENTRY_COMMIT_CLR_EN
        chk("enter_buf", 32'(din), 32'hFFFF);
`else
        chk("enter_buf", 32'(din), 32'hFF56);
`endif

        send(4'hB); idle(5);
        key_vld = 1'b1;
        key_val = 4'h7; idle(1);
        key_val = 4'h8; idle(1);
        key_val = 4'h9; idle(1);
        key_vld = 1'b0;
        chk("burst_drop", 32'(key_drop), 32'h1);
        idle(12);
        chk("burst_din", 32'(din), 32'hFF78);

        send(4'h1);
        idle(3);
        send(4'hB);
        idle(6);
        chk("last_cycle_hold", 32'(din), 32'hFFFF);
        send(4'hD);
        chk("ignore_code", 32'(din_vld), 32'h0);
        chk("ignore_nodrop", 32'(key_drop), 32'h0);
        idle(2);

        send(4'h3);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("rst_abort", 32'(din_vld), 32'h0);
        chk("rst_abort_din", 32'(din), 32'hFFFF);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("reinit_sweep", 32'(din_vld), 32'h1);
        send(4'h4);
        idle(10);
        chk("init_hold_key", 32'(din), 32'hFFF4);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
